// File: rtl/inc_arbiter.sv
// inc_arbiter: round-robin arbiter in front of a shared WIDTH-bit incrementer.
// A request is granted in IDLE, the operand is incremented in EXEC, and the
// result is held in RESP until the consumer takes it.
// Optional feature macro: INC_ARB_SATURATE_EN (saturating instead of wrapping
// increment; rsp_ovf then flags that saturation happened).
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; valid never waits on ready, and the payload
// must stay stable while valid is high and the transfer has not happened.
module inc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_ovf,
   output logic [1:0]               o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_id;
   logic [WIDTH-1:0]    r_op;
   logic [WIDTH-1:0]    r_res;
   logic                r_ovf;

   logic                w_found;
   logic [ID_W-1:0]     w_win;
   logic [WIDTH-1:0]    w_win_data;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_accept;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic                w_op_max;
   logic [WIDTH-1:0]    w_inc;

   // Pick the first valid requester scanning upward from the pointer, with wrap.
   always_comb begin
      int idx;
      idx        = 0;
      w_found    = 1'b0;
      w_win      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_win   = ID_W'(idx);
         end
      end
      w_win_data = req_data[w_win*WIDTH +: WIDTH];
   end

   // Grant is only offered in IDLE and never while reset is asserted.
   always_comb begin
      w_grant   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
      req_ready = (!rst && (r_state == ST_IDLE) && w_found) ? w_grant : '0;
      w_accept  = |(req_valid & req_ready);
      w_ptr_nxt = (w_win == ID_W'(NUM_REQ-1)) ? '0 : (w_win + ID_W'(1));
   end

   // Increment result; the all-ones operand either wraps or saturates.
   always_comb begin
      w_op_max = &r_op;
`ifdef INC_ARB_SATURATE_EN
      w_inc    = w_op_max ? r_op : (r_op + WIDTH'(1));
`else
      w_inc    = r_op + WIDTH'(1);
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state: IDLE -> EXEC on grant, EXEC -> RESP always, RESP -> IDLE on take.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
         ST_EXEC:                w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch operand/tag/pointer on accept, compute result in EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_id  <= '0;
         r_op  <= '0;
         r_res <= '0;
         r_ovf <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_accept) begin
            r_op  <= w_win_data;
            r_id  <= w_win;
            r_ptr <= w_ptr_nxt;
         end
         if (r_state == ST_EXEC) begin
            r_res <= w_inc;
            r_ovf <= w_op_max;
         end
      end
   end

   assign rsp_valid   = (r_state == ST_RESP);
   assign rsp_data    = r_res;
   assign rsp_id      = r_id;
   assign rsp_ovf     = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter (NUM_REQ=4, WIDTH=8): table of single operations from
// reset, then hand-written fairness, backpressure, pointer-wrap and
// mid-operation reset sequences.
module tb_inc_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
`ifdef INC_ARB_SATURATE_EN
   localparam logic [7:0] OVF_RES = 8'hFF;
`else
   localparam logic [7:0] OVF_RES = 8'h00;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ovf;
   logic [1:0]  dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   logic [9:0] exp_q[$];

   inc_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .rsp_ovf     (rsp_ovf),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task do_reset;
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // driver: one complete operation with rsp_ready high
   task serve(input string name, input logic [3:0] valid, input logic [31:0] data,
              input logic [3:0] exp_ready, input logic [1:0] exp_id,
              input logic [7:0] exp_data, input logic exp_ovf);
      rsp_ready = 1'b1;
      req_data  = data;
      req_valid = valid;
      #1;
      chk({name, " req_ready"}, 32'(req_ready), 32'(exp_ready));
      tick();
      req_valid = '0;
      chk({name, " valid_exec"}, 32'(rsp_valid), 32'd0);
      tick();
      chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
      chk({name, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
      chk({name, " rsp_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
      tick();
      chk({name, " valid_after"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      logic [1:0]  exp_id;
      logic [7:0]  exp_data;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int cyc;
      int last_cyc;
      int got;
      logic [9:0] exp_e;

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;

      // reset state, with every requester valid while reset is held
      tick();
      req_valid = 4'b1111;
      #1;
      chk("rst req_ready", 32'(req_ready), 32'd0);
      tick();
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_data", 32'(rsp_data), 32'd0);
      chk("rst rsp_id", 32'(rsp_id), 32'd0);
      chk("rst rsp_ovf", 32'(rsp_ovf), 32'd0);
      chk("rst state", 32'(dbg_state), 32'd0);

      // table of single operations, each from reset (pointer 0)
      vecs[0] = '{4'b0001, 32'h0000_0012, 4'b0001, 2'd0, 8'h13, 1'b0};
      vecs[1] = '{4'b0100, 32'h00FF_0000, 4'b0100, 2'd2, OVF_RES, 1'b1};
      vecs[2] = '{4'b0110, 32'h0001_7F00, 4'b0010, 2'd1, 8'h80, 1'b0};
      vecs[3] = '{4'b1000, 32'hFE00_0000, 4'b1000, 2'd3, 8'hFF, 1'b0};
      vecs[4] = '{4'b1111, 32'h4030_2010, 4'b0001, 2'd0, 8'h11, 1'b0};
      vecs[5] = '{4'b1100, 32'h0500_0000, 4'b0100, 2'd2, 8'h01, 1'b0};
      vecs[6] = '{4'b0001, 32'h0000_00FF, 4'b0001, 2'd0, OVF_RES, 1'b1};
      for (int i = 0; i < 7; i++) begin
         do_reset();
         serve($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].exp_ready,
               vecs[i].exp_id, vecs[i].exp_data, vecs[i].exp_ovf);
      end

      // fairness: all valid, one result every 3 cycles, ids 0,1,2,3,0
      do_reset();
      exp_q.push_back({2'd0, 8'h11});
      exp_q.push_back({2'd1, 8'h21});
      exp_q.push_back({2'd2, 8'h31});
      exp_q.push_back({2'd3, 8'h41});
      exp_q.push_back({2'd0, 8'h11});
      req_data  = 32'h4030_2010;
      req_valid = 4'b1111;
      got      = 0;
      last_cyc = 0;
      cyc      = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         tick();
         cyc++;
         if (rsp_valid) begin
            exp_e = exp_q.pop_front();
            chk($sformatf("fair%0d rsp_id", got), 32'(rsp_id), 32'(exp_e[9:8]));
            chk($sformatf("fair%0d rsp_data", got), 32'(rsp_data), 32'(exp_e[7:0]));
            if (got > 0) chk($sformatf("fair%0d spacing", got), 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            got++;
         end
      end
      chk("fair pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      req_valid = '0;
      tick();
      tick();

      // backpressure: hold RESP for 5 cycles while requester 1 waits
      do_reset();
      rsp_ready = 1'b0;
      req_data  = 32'h0000_2012;
      req_valid = 4'b0001;
      #1;
      chk("bp grant0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b0010;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp%0d rsp_data", i), 32'(rsp_data), 32'h13);
         chk($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 32'd0);
         chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp ready_in_resp", 32'(req_ready), 32'd0);
      tick();
      chk("bp rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("bp grant1", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      tick();
      chk("bp r1 rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp r1 rsp_id", 32'(rsp_id), 32'd1);
      chk("bp r1 rsp_data", 32'(rsp_data), 32'h21);
      tick();

      // pointer wrap: serve 2 (ptr->3), then 3 (ptr->0), then 0 wins over 3
      do_reset();
      serve("wrap r2", 4'b0100, 32'h0007_0000, 4'b0100, 2'd2, 8'h08, 1'b0);
      serve("wrap r3", 4'b1001, 32'h3000_0001, 4'b1000, 2'd3, 8'h31, 1'b0);
      serve("wrap r0", 4'b1001, 32'h3000_0001, 4'b0001, 2'd0, 8'h02, 1'b0);

      // reset in EXEC: pointer was 3, operation must vanish, next grant to 0
      do_reset();
      serve("mid pre", 4'b0100, 32'h0007_0000, 4'b0100, 2'd2, 8'h08, 1'b0);
      req_data  = 32'h0000_4400;
      req_valid = 4'b0010;
      #1;
      chk("mid grant", 32'(req_ready), 32'b0010);
      tick();
      chk("mid in_exec", 32'(dbg_state), 32'd1);
      req_valid = 4'b1111;
      rst       = 1'b1;
      #1;
      chk("mid rst req_ready", 32'(req_ready), 32'd0);
      tick();
      chk("mid rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid rsp_data", 32'(rsp_data), 32'd0);
      chk("mid rsp_id", 32'(rsp_id), 32'd0);
      chk("mid rsp_ovf", 32'(rsp_ovf), 32'd0);
      chk("mid req_ready", 32'(req_ready), 32'd0);
      rst       = 1'b0;
      req_valid = '0;
      got = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) got++;
      end
      chk("mid no_rsp", 32'(got), 32'd0);
      serve("mid next", 4'b1111, 32'h4030_2010, 4'b0001, 2'd0, 8'h11, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
